// File: rtl/ah_dedup_credit_sender.sv
// ah_dedup_credit_sender
// Producer-side injector for a snoopable credit FIFO. Each accepted word sits
// in a one-entry hold stage for a compare cycle. In that cycle it is checked
// against the FIFO contents (through the snoop port) and against the word
// being written. Duplicates are dropped when dedup is enabled. Surviving words
// are written under a credit counter that mirrors the FIFO's free space.
module ah_dedup_credit_sender #(
    parameter int DATA_WIDTH = 10,
    parameter int CREDITS    = 16,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic                  dedup_en_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_valid_o,
    input  logic                  credit_in_i,
    output logic [DATA_WIDTH-1:0] snoop_data_o,
    output logic                  snoop_valid_o,
    input  logic                  snoop_match_i,
    output logic [CNT_WIDTH-1:0]  credit_count_o,
    output logic [15:0]           drop_count_o,
    output logic                  credit_err_o
);

    localparam logic [CNT_WIDTH-1:0] CREDITS_C = CNT_WIDTH'(CREDITS);

    logic                  hold_valid_q, hold_valid_d;
    logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [CNT_WIDTH-1:0]  credit_q, credit_d;
    logic [15:0]           drop_q, drop_d;
    logic                  err_q, err_d;

    logic dup;
    logic have_credit;
    logic send;
    logic hold_leave;
    logic accept;

    // Duplicate detection, send/drop decision and producer handshake.
    // The out_data compare catches the word being written this cycle, which
    // the FIFO cannot report through snoop_match yet.
    always_comb begin
        dup         = dedup_en_i && hold_valid_q &&
                      (snoop_match_i || (out_valid_q && (out_data_q == hold_data_q)));
        have_credit = (credit_q != '0);
        send        = hold_valid_q && !dup && have_credit;
        hold_leave  = hold_valid_q && (dup || have_credit);
        in_ready_o  = !hold_valid_q || hold_leave;
        accept      = in_valid_i && in_ready_o;
    end

    // Next-state for the hold stage, write port, credit counter and statistics.
    // A credit arriving together with a send leaves the count unchanged; a
    // credit with no room left is an overflow and is latched in credit_err.
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        out_valid_d  = send;
        out_data_d   = out_data_q;
        credit_d     = credit_q;
        drop_d       = drop_q;
        err_d        = err_q;

        if (accept) begin
            hold_valid_d = 1'b1;
            hold_data_d  = in_data_i;
        end else if (hold_leave) begin
            hold_valid_d = 1'b0;
        end

        if (send) begin
            out_data_d = hold_data_q;
        end

        if (dup && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end

        case ({send, credit_in_i})
            2'b10: credit_d = credit_q - 1'b1;
            2'b01: begin
                if (credit_q == CREDITS_C) begin
                    err_d = 1'b1;
                end else begin
                    credit_d = credit_q + 1'b1;
                end
            end
            default: credit_d = credit_q;
        endcase
    end

    // State registers; reset discards the held word and any pending write.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            credit_q     <= CREDITS_C;
            drop_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            credit_q     <= credit_d;
            drop_q       <= drop_d;
            err_q        <= err_d;
        end
    end

    assign snoop_valid_o  = hold_valid_q && dedup_en_i;
    assign snoop_data_o   = hold_data_q;
    assign out_valid_o    = out_valid_q;
    assign out_data_o     = out_data_q;
    assign credit_count_o = credit_q;
    assign drop_count_o   = drop_q;
    assign credit_err_o   = err_q;

endmodule

// File: tb/tb_ah_dedup_credit_sender.sv
// Bench for ah_dedup_credit_sender: directed vector table, hand-written corner
// sequences and a randomized run, all compared against a transaction-level
// model of the sender.
module tb_ah_dedup_credit_sender;

    localparam int DW = 10;
    localparam int CR = 16;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rstn;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          dedup_en;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          credit_in;
    logic [DW-1:0] snoop_data;
    logic          snoop_valid;
    logic          snoop_match;
    logic [CW-1:0] credit_count;
    logic [15:0]   drop_count;
    logic          credit_err;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    ah_dedup_credit_sender #(.DATA_WIDTH(DW), .CREDITS(CR), .CNT_WIDTH(CW)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .in_data_i     (in_data),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .dedup_en_i    (dedup_en),
        .out_data_o    (out_data),
        .out_valid_o   (out_valid),
        .credit_in_i   (credit_in),
        .snoop_data_o  (snoop_data),
        .snoop_valid_o (snoop_valid),
        .snoop_match_i (snoop_match),
        .credit_count_o(credit_count),
        .drop_count_o  (drop_count),
        .credit_err_o  (credit_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // The held word is a queue of at most one entry; credits and drops are
    // plain integers clamped by the rules of the protocol.
    logic [DW-1:0] held[$];
    logic [DW-1:0] m_last_hold;
    bit            m_wr;
    logic [DW-1:0] m_wr_data;
    int            m_cred;
    int            m_drops;
    bit            m_err;
    bit            last_stall;

    task automatic model_reset();
        held.delete();
        m_last_hold = '0;
        m_wr        = 0;
        m_wr_data   = '0;
        m_cred      = CR;
        m_drops     = 0;
        m_err       = 0;
        last_stall  = 0;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_is_dup();
        if (!dedup_en || held.size() == 0) return 0;
        return snoop_match || (m_wr && m_wr_data == held[0]);
    endfunction

    function automatic bit m_ready();
        if (held.size() == 0) return 1;
        return m_is_dup() || m_cred > 0;
    endfunction

    // Compare outputs mid-cycle, advance the model across the next edge.
    task automatic do_cycle();
        bit dup, rdy, sent;
        dup  = m_is_dup();
        rdy  = m_ready();
        chk("in_ready",     int'(in_ready),    int'(rdy));
        chk("snoop_valid",  int'(snoop_valid), int'(dedup_en && held.size() != 0));
        chk("snoop_data",   int'(snoop_data),  int'(m_last_hold));
        chk("out_valid",    int'(out_valid),   int'(m_wr));
        chk("out_data",     int'(out_data),    int'(m_wr_data));
        chk("credit_count", int'(credit_count), m_cred);
        chk("drop_count",   int'(drop_count),  m_drops);
        chk("credit_err",   int'(credit_err),  int'(m_err));
        if (out_valid) pulses++;

        sent = (held.size() != 0) && !dup && (m_cred > 0);
        if (dup && m_drops < 65535) m_drops++;
        m_wr = sent;
        if (sent) m_wr_data = held[0];
        m_cred = m_cred + int'(credit_in) - int'(sent);
        if (m_cred > CR) begin
            m_cred = CR;
            m_err  = 1;
        end
        if (held.size() != 0 && (dup || sent)) void'(held.pop_front());
        last_stall = in_valid && !rdy;
        if (in_valid && rdy) begin
            held.push_back(in_data);
            m_last_hold = in_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
        do_cycle();
    endtask

    task automatic idle_inputs();
        in_valid    = 0;
        in_data     = '0;
        credit_in   = 0;
        snoop_match = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rstn = 0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1;
    endtask

    typedef struct {
        bit            iv;
        logic [DW-1:0] d;
        bit            de;
        bit            sm;
        bit            ci;
        bit            e_rdy;
        bit            e_sv;
        bit            e_ov;
        logic [DW-1:0] e_od;
        int            e_cred;
        int            e_drop;
    } vec_t;

    vec_t vt[10];

    initial begin
        rstn = 1;
        dedup_en = 0;
        idle_inputs();
        model_reset();

        // Reset values while rstn is held low.
        @(posedge clk);
        #1;
        rstn = 0;
        #2;
        chk("rst in_ready",     int'(in_ready),     1);
        chk("rst snoop_valid",  int'(snoop_valid),  0);
        chk("rst out_valid",    int'(out_valid),    0);
        chk("rst out_data",     int'(out_data),     0);
        chk("rst credit_count", int'(credit_count), 16);
        chk("rst drop_count",   int'(drop_count),   0);
        chk("rst credit_err",   int'(credit_err),   0);
        do_reset();

        // Vector table: back-to-back duplicate, snoop hit, dedup disabled.
        vt[0] = '{1, 10'h055, 1, 0, 0, 1, 0, 0, 10'h000, 16, 0};
        vt[1] = '{1, 10'h055, 1, 0, 0, 1, 1, 0, 10'h000, 16, 0};
        vt[2] = '{0, 10'h000, 1, 0, 0, 1, 1, 1, 10'h055, 15, 0};
        vt[3] = '{0, 10'h000, 1, 0, 0, 1, 0, 0, 10'h055, 15, 1};
        vt[4] = '{1, 10'h123, 1, 0, 0, 1, 0, 0, 10'h055, 15, 1};
        vt[5] = '{0, 10'h000, 1, 1, 0, 1, 1, 0, 10'h055, 15, 1};
        vt[6] = '{1, 10'h123, 0, 0, 0, 1, 0, 0, 10'h055, 15, 2};
        vt[7] = '{0, 10'h000, 0, 1, 0, 1, 0, 0, 10'h055, 15, 2};
        vt[8] = '{0, 10'h000, 0, 0, 0, 1, 0, 1, 10'h123, 14, 2};
        vt[9] = '{0, 10'h000, 0, 0, 0, 1, 0, 0, 10'h123, 14, 2};
        for (int i = 0; i < 10; i++) begin
            in_valid    = vt[i].iv;
            in_data     = vt[i].d;
            dedup_en    = vt[i].de;
            snoop_match = vt[i].sm;
            credit_in   = vt[i].ci;
            @(negedge clk);
            chk($sformatf("vec%0d in_ready", i),     int'(in_ready),     int'(vt[i].e_rdy));
            chk($sformatf("vec%0d snoop_valid", i),  int'(snoop_valid),  int'(vt[i].e_sv));
            chk($sformatf("vec%0d out_valid", i),    int'(out_valid),    int'(vt[i].e_ov));
            chk($sformatf("vec%0d out_data", i),     int'(out_data),     int'(vt[i].e_od));
            chk($sformatf("vec%0d credit_count", i), int'(credit_count), vt[i].e_cred);
            chk($sformatf("vec%0d drop_count", i),   int'(drop_count),   vt[i].e_drop);
            do_cycle();
        end

        // Drain all 16 credits, stall the 17th word, release it with one credit.
        dedup_en = 0;
        do_reset();
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1;
            in_data  = DW'(i + 100);
            tick();
        end
        in_data = 10'h3AA;
        tick();
        idle_inputs();
        tick();
        tick();
        chk("fill pulses",       pulses,             16);
        chk("fill credit_count", int'(credit_count), 0);
        chk("stall in_ready",    int'(in_ready),     0);
        credit_in = 1;
        tick();
        credit_in = 0;
        chk("stall still held",  int'(out_valid),    0);
        tick();
        chk("release out_valid", int'(out_valid),    1);
        chk("release out_data",  int'(out_data),     10'h3AA);
        chk("release credits",   int'(credit_count), 0);

        // Credit arriving together with a send leaves the count unchanged.
        credit_in = 1;
        repeat (5) tick();
        credit_in = 0;
        in_valid  = 1;
        in_data   = 10'h2AB;
        tick();
        in_valid  = 0;
        credit_in = 1;
        tick();
        credit_in = 0;
        chk("send+credit count", int'(credit_count), 5);
        // Overflow at full credits sets the sticky error.
        credit_in = 1;
        repeat (11) tick();
        chk("full count",        int'(credit_count), 16);
        chk("no err yet",        int'(credit_err),   0);
        tick();
        credit_in = 0;
        chk("overflow count",    int'(credit_count), 16);
        chk("overflow err",      int'(credit_err),   1);
        repeat (3) tick();
        chk("err sticky",        int'(credit_err),   1);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (!last_stall) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = DW'($urandom_range(0, 3));
            end
            dedup_en    = ($urandom_range(0, 3) != 0);
            snoop_match = ($urandom_range(0, 9) == 0);
            credit_in   = ($urandom_range(0, 2) == 0);
            tick();
        end
        idle_inputs();

        // Reset in the middle of a stream with a held word and three credits left.
        dedup_en = 0;
        do_reset();
        for (int i = 0; i < 14; i++) begin
            in_valid = 1;
            in_data  = DW'(i + 200);
            tick();
        end
        in_valid = 0;
        chk("pre-reset credits",   int'(credit_count), 3);
        chk("pre-reset out_valid", int'(out_valid),    1);
        rstn = 0;
        #1;
        chk("mid rst out_valid",    int'(out_valid),    0);
        chk("mid rst out_data",     int'(out_data),     0);
        chk("mid rst credit_count", int'(credit_count), 16);
        chk("mid rst in_ready",     int'(in_ready),     1);
        chk("mid rst snoop_valid",  int'(snoop_valid),  0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1;
        pulses = 0;
        repeat (4) tick();
        chk("post-reset no pulse", pulses, 0);
        in_valid = 1;
        in_data  = 10'h1F0;
        tick();
        in_valid = 0;
        tick();
        chk("post-reset out_valid", int'(out_valid), 1);
        chk("post-reset out_data",  int'(out_data),  10'h1F0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
